// File: rtl/frame_fifo_arb_pkg.sv
// Shared definitions for the frame-granular FIFO read-port arbiter:
// state encoding and drop counter width.
package frame_fifo_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_STREAM  = 2'd3;

  localparam int DROP_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT   = ST_GRANT,
    DISCARD = ST_DISCARD,
    STREAM  = ST_STREAM
  } arb_state_t;

endpackage

// File: rtl/frame_fifo_rr_select.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_SOURCES.
module frame_fifo_rr_select
  import frame_fifo_arb_pkg::*;
#(
  parameter int NUM_SOURCES  = 4,
  parameter int SRC_ID_WIDTH = 2
) (
  input  logic [NUM_SOURCES-1:0]  req,
  input  logic [SRC_ID_WIDTH-1:0] rr_ptr,
  output logic [SRC_ID_WIDTH-1:0] grant_idx,
  output logic                    grant_valid
);

  int idx_s;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx_s       = 0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      idx_s = int'(rr_ptr) + i;
      if (idx_s >= NUM_SOURCES) begin
        idx_s = idx_s - NUM_SOURCES;
      end else begin
        idx_s = idx_s;
      end
      if (req[idx_s]) begin
        grant_idx   = idx_s[SRC_ID_WIDTH-1:0];
        grant_valid = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/frame_fifo_frame_arbiter.sv
// Shares one frame FIFO read port among NUM_SOURCES lane FIFOs, one whole
// frame at a time, rotating round-robin only at frame boundaries.
module frame_fifo_frame_arbiter
  import frame_fifo_arb_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 32,
  parameter int NUM_SOURCES      = 4,
  parameter int SRC_ID_WIDTH     = 2,
  parameter int LINE_COUNT_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_enable,
  input  logic [LINE_COUNT_WIDTH-1:0]            i_lines_per_frame,
  input  logic [NUM_SOURCES-1:0]                 i_src_ready,
  output logic [NUM_SOURCES-1:0]                 o_src_next_stb,
  input  logic [NUM_SOURCES-1:0]                 i_src_sof,
  input  logic [NUM_SOURCES-1:0]                 i_src_last,
  input  logic [NUM_SOURCES*AXIS_DATA_WIDTH-1:0] i_src_data,
  output logic                                   o_frame_fifo_ready,
  input  logic                                   i_frame_fifo_next_stb,
  output logic                                   o_frame_fifo_sof,
  output logic                                   o_frame_fifo_last,
  output logic [AXIS_DATA_WIDTH-1:0]             o_frame_fifo_data,
  output logic [SRC_ID_WIDTH-1:0]                o_active_src,
  output logic                                   o_busy,
  output logic                                   o_short_frame_stb,
  output logic [DROP_COUNT_WIDTH-1:0]            o_drop_count
);

  arb_state_t                    state_r, state_s;
  logic [SRC_ID_WIDTH-1:0]       rr_ptr_r, active_src_r, next_ptr_s, sel_idx_s;
  logic [LINE_COUNT_WIDTH-1:0]   lines_cfg_r, line_cnt_r;
  logic                          beat_cnt_r, short_frame_r, sel_valid_s;
  logic [DROP_COUNT_WIDTH-1:0]   drop_count_r;
  logic                          grant_ready_s, grant_sof_s, grant_last_s;
  logic [AXIS_DATA_WIDTH-1:0]    grant_data_s;
  logic                          out_ready_s, xfer_s, abort_s, frame_end_s, discard_pop_s;
  logic [NUM_SOURCES-1:0]        next_stb_s;
  logic                          is_stream_s;

  frame_fifo_rr_select #(
    .NUM_SOURCES (NUM_SOURCES),
    .SRC_ID_WIDTH(SRC_ID_WIDTH)
  ) u_rr_select (
    .req        (i_src_ready),
    .rr_ptr     (rr_ptr_r),
    .grant_idx  (sel_idx_s),
    .grant_valid(sel_valid_s)
  );

  assign grant_ready_s = i_src_ready[active_src_r];
  assign grant_sof_s   = i_src_sof[active_src_r];
  assign grant_last_s  = i_src_last[active_src_r];
  assign grant_data_s  = i_src_data[active_src_r*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign next_ptr_s    = (active_src_r == SRC_ID_WIDTH'(NUM_SOURCES - 1))
                         ? '0 : active_src_r + SRC_ID_WIDTH'(1);
  assign is_stream_s   = (state_r == STREAM);

  // Next-state and pass-through/pop strobes for the granted source.
  always_comb begin
    state_s       = state_r;
    out_ready_s   = 1'b0;
    next_stb_s    = '0;
    xfer_s        = 1'b0;
    abort_s       = 1'b0;
    frame_end_s   = 1'b0;
    discard_pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_enable && (|i_src_ready)) state_s = GRANT;
        else                            state_s = IDLE;
      end
      GRANT: begin
        if (sel_valid_s) state_s = i_src_sof[sel_idx_s] ? STREAM : DISCARD;
        else             state_s = IDLE;
      end
      DISCARD: begin
        if (grant_ready_s) begin
          if (grant_sof_s) begin
            state_s = STREAM;
          end else begin
            next_stb_s[active_src_r] = 1'b1;
            discard_pop_s            = 1'b1;
          end
        end else begin
          state_s = DISCARD;
        end
      end
      STREAM: begin
        // A fresh sof mid-frame means the current frame was cut short.
        abort_s     = grant_ready_s & grant_sof_s & ((line_cnt_r != '0) | beat_cnt_r);
        out_ready_s = grant_ready_s & ~abort_s;
        xfer_s      = i_frame_fifo_next_stb & out_ready_s;
        next_stb_s[active_src_r] = xfer_s;
        frame_end_s = xfer_s & grant_last_s &
                      (line_cnt_r == (lines_cfg_r - LINE_COUNT_WIDTH'(1)));
        if (abort_s)          state_s = GRANT;
        else if (frame_end_s) state_s = i_enable ? GRANT : IDLE;
        else                  state_s = STREAM;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, grant bookkeeping, frame counters and drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      active_src_r  <= '0;
      lines_cfg_r   <= LINE_COUNT_WIDTH'(1);
      line_cnt_r    <= '0;
      beat_cnt_r    <= 1'b0;
      drop_count_r  <= '0;
      short_frame_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      short_frame_r <= abort_s;
      if (state_r == GRANT) begin
        line_cnt_r <= '0;
        beat_cnt_r <= 1'b0;
        if (sel_valid_s) begin
          active_src_r <= sel_idx_s;
          lines_cfg_r  <= (i_lines_per_frame == '0) ? LINE_COUNT_WIDTH'(1) : i_lines_per_frame;
        end
      end
      if (discard_pop_s && (drop_count_r != '1)) begin
        drop_count_r <= drop_count_r + DROP_COUNT_WIDTH'(1);
      end
      if (xfer_s) begin
        if (grant_last_s) begin
          line_cnt_r <= line_cnt_r + LINE_COUNT_WIDTH'(1);
          beat_cnt_r <= 1'b0;
        end else begin
          beat_cnt_r <= 1'b1;
        end
      end
      if (abort_s || frame_end_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  assign o_frame_fifo_ready = out_ready_s;
  assign o_src_next_stb     = next_stb_s;
  assign o_frame_fifo_sof   = is_stream_s & grant_sof_s;
  assign o_frame_fifo_last  = is_stream_s & grant_last_s;
  assign o_frame_fifo_data  = is_stream_s ? grant_data_s : '0;
  assign o_active_src       = active_src_r;
  assign o_busy             = (state_r == DISCARD) || (state_r == STREAM);
  assign o_short_frame_stb  = short_frame_r;
  assign o_drop_count       = drop_count_r;

endmodule

// File: tb/tb_frame_fifo_frame_arbiter.sv
// Directed bench for frame_fifo_frame_arbiter: behavioural source FIFOs,
// downstream word log, per-scenario inline comparisons.
module tb_frame_fifo_frame_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst, i_enable, i_frame_fifo_next_stb;
  logic [LW-1:0]   i_lines_per_frame;
  logic [N-1:0]    i_src_ready, i_src_sof, i_src_last, o_src_next_stb;
  logic [N*W-1:0]  i_src_data;
  logic            o_frame_fifo_ready, o_frame_fifo_sof, o_frame_fifo_last;
  logic [W-1:0]    o_frame_fifo_data;
  logic [SW-1:0]   o_active_src;
  logic            o_busy, o_short_frame_stb;
  logic [15:0]     o_drop_count;

  always #5 clk = ~clk;

  frame_fifo_frame_arbiter #(
    .AXIS_DATA_WIDTH(W), .NUM_SOURCES(N), .SRC_ID_WIDTH(SW), .LINE_COUNT_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_lines_per_frame(i_lines_per_frame),
    .i_src_ready(i_src_ready), .o_src_next_stb(o_src_next_stb), .i_src_sof(i_src_sof),
    .i_src_last(i_src_last), .i_src_data(i_src_data), .o_frame_fifo_ready(o_frame_fifo_ready),
    .i_frame_fifo_next_stb(i_frame_fifo_next_stb), .o_frame_fifo_sof(o_frame_fifo_sof),
    .o_frame_fifo_last(o_frame_fifo_last), .o_frame_fifo_data(o_frame_fifo_data),
    .o_active_src(o_active_src), .o_busy(o_busy), .o_short_frame_stb(o_short_frame_stb),
    .o_drop_count(o_drop_count)
  );

  // Source FIFO model: {sof, last, data}
  logic [33:0] mem [N][64];
  int          head [N];
  int          tail [N];
  // Word records: {src, sof, last, data}
  logic [35:0] exp_q [64];
  logic [35:0] rx_q  [64];
  int          rx_cyc [64];
  int          exp_n, rx_n, cyc, short_cnt;
  bit          rand_stb, chk_pop;
  int          n_cmp, n_err;

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      if (head[k] < tail[k]) begin
        i_src_ready[k]        = 1'b1;
        i_src_sof[k]          = mem[k][head[k]][33];
        i_src_last[k]         = mem[k][head[k]][32];
        i_src_data[k*W +: W]  = mem[k][head[k]][31:0];
      end else begin
        i_src_ready[k]        = 1'b0;
        i_src_sof[k]          = 1'b0;
        i_src_last[k]         = 1'b0;
        i_src_data[k*W +: W]  = 32'h0;
      end
    end
    if (rand_stb) i_frame_fifo_next_stb = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int s, input bit sof, input bit last, input logic [31:0] d);
    mem[s][tail[s]] = {sof, last, d};
    tail[s]++;
  endtask

  task automatic load_frame(input int s, input int lines, input int beats, input logic [31:0] base);
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < beats; b++)
        push(s, (l == 0) && (b == 0), b == beats - 1, base + 32'(l * 16 + b));
  endtask

  task automatic exp_frame(input int s, input int lines, input int beats, input logic [31:0] base);
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < beats; b++) begin
        exp_q[exp_n] = {2'(s), 1'((l == 0) && (b == 0)), 1'(b == beats - 1), base + 32'(l * 16 + b)};
        exp_n++;
      end
  endtask

  task automatic clear_log();
    exp_n = 0; rx_n = 0; cyc = 0; short_cnt = 0;
    for (int i = 0; i < 64; i++) begin rx_q[i] = '1; rx_cyc[i] = -1; end
  endtask

  task automatic cycle();
    logic [N-1:0] pops;
    logic [N-1:0] mask;
    @(negedge clk);
    if (o_short_frame_stb === 1'b1) short_cnt++;
    if (chk_pop) begin
      mask = i_frame_fifo_next_stb ? 4'b1110 : 4'b1111;
      n_cmp++;
      if ((o_src_next_stb & mask) !== 4'b0000) begin
        n_err++;
        $display("FAIL pop_gating cyc=%0d next_stb=%b got pops=%b, required none outside src0 transfers",
                 cyc, i_frame_fifo_next_stb, o_src_next_stb);
      end
    end
    if (o_frame_fifo_ready === 1'b1 && i_frame_fifo_next_stb === 1'b1 && rx_n < 64) begin
      rx_q[rx_n]   = {o_active_src, o_frame_fifo_sof, o_frame_fifo_last, o_frame_fifo_data};
      rx_cyc[rx_n] = cyc;
      rx_n++;
    end
    pops = o_src_next_stb;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (pops[k] === 1'b1) begin
        if (head[k] < tail[k]) head[k]++;
        else begin
          n_cmp++; n_err++;
          $display("FAIL pop_empty src=%0d popped while empty, required no pop", k);
        end
      end
    end
    cyc++;
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_enable = 1'b0; i_frame_fifo_next_stb = 1'b1; i_lines_per_frame = 16'd1;
    rand_stb = 1'b0; chk_pop = 1'b0;
    for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end
    clear_log(); refresh();
    run(2);
    n_cmp++; if ({o_frame_fifo_ready, o_busy, o_short_frame_stb} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags got %b required 000", {o_frame_fifo_ready, o_busy, o_short_frame_stb}); end
    n_cmp++; if (o_src_next_stb !== 4'b0000) begin n_err++; $display("FAIL reset_pop got %b required 0000", o_src_next_stb); end
    n_cmp++; if (o_active_src !== 2'd0) begin n_err++; $display("FAIL reset_active got %0d required 0", o_active_src); end
    n_cmp++; if (o_drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop got %0d required 0", o_drop_count); end
    n_cmp++; if ({o_frame_fifo_sof, o_frame_fifo_last, o_frame_fifo_data} !== 34'd0) begin n_err++;
      $display("FAIL reset_data got %h required 0", o_frame_fifo_data); end
    rst = 1'b0;
  endtask

  task automatic test_two_frames();
    i_enable = 1'b1; i_lines_per_frame = 16'd2; clear_log();
    load_frame(0, 2, 4, 32'h0A00_0000); load_frame(2, 2, 4, 32'h0C00_0000);
    exp_frame(0, 2, 4, 32'h0A00_0000); exp_frame(2, 2, 4, 32'h0C00_0000);
    refresh(); run(30);
    n_cmp++; if (rx_n !== exp_n) begin n_err++; $display("FAIL two_frames_count got %0d required %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL two_frames_word%0d got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (rx_cyc[0] !== 2) begin n_err++; $display("FAIL grant_latency got cycle %0d required 2", rx_cyc[0]); end
    n_cmp++; if (rx_cyc[8] !== rx_cyc[7] + 2) begin n_err++;
      $display("FAIL frame_gap got %0d cycles required 2", rx_cyc[8] - rx_cyc[7]); end
  endtask

  task automatic test_discard();
    i_lines_per_frame = 16'd1; clear_log();
    push(1, 1'b0, 1'b0, 32'hDEAD_0001); push(1, 1'b0, 1'b1, 32'hDEAD_0002); push(1, 1'b0, 1'b0, 32'hDEAD_0003);
    load_frame(1, 1, 2, 32'h0B00_0000); exp_frame(1, 1, 2, 32'h0B00_0000);
    refresh(); run(15);
    n_cmp++; if (o_drop_count !== 16'd3) begin n_err++; $display("FAIL discard_count got %0d required 3", o_drop_count); end
    n_cmp++; if (head[1] !== tail[1]) begin n_err++; $display("FAIL discard_pops got %0d left required 0", tail[1] - head[1]); end
    n_cmp++; if (rx_n !== exp_n) begin n_err++; $display("FAIL discard_rx_count got %0d required %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL discard_word%0d got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    i_lines_per_frame = 16'd3; clear_log();
    push(1, 1'b1, 1'b0, 32'h0E00_0000); push(1, 1'b0, 1'b1, 32'h0E00_0001);
    load_frame(1, 3, 1, 32'h0F00_0000);
    exp_q[0] = {2'd1, 1'b1, 1'b0, 32'h0E00_0000}; exp_q[1] = {2'd1, 1'b0, 1'b1, 32'h0E00_0001}; exp_n = 2;
    exp_frame(2, 3, 1, 32'h0D00_0000); exp_frame(1, 3, 1, 32'h0F00_0000);
    refresh(); run(3);
    load_frame(2, 3, 1, 32'h0D00_0000); refresh();
    run(17);
    n_cmp++; if (short_cnt !== 1) begin n_err++; $display("FAIL abort_pulses got %0d required 1", short_cnt); end
    n_cmp++; if (rx_n !== exp_n) begin n_err++; $display("FAIL abort_rx_count got %0d required %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_word%0d got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (o_drop_count !== 16'd3) begin n_err++; $display("FAIL abort_drop got %0d required 3", o_drop_count); end
  endtask

  task automatic test_random_pop();
    i_lines_per_frame = 16'd2; clear_log();
    load_frame(0, 2, 3, 32'h0100_0000); exp_frame(0, 2, 3, 32'h0100_0000);
    rand_stb = 1'b1; chk_pop = 1'b1; refresh();
    run(50);
    rand_stb = 1'b0; chk_pop = 1'b0; i_frame_fifo_next_stb = 1'b1; refresh();
    run(4);
    n_cmp++; if (rx_n !== exp_n) begin n_err++; $display("FAIL random_rx_count got %0d required %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_word%0d got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (head[0] !== tail[0]) begin n_err++; $display("FAIL random_pops got %0d left required 0", tail[0] - head[0]); end
  endtask

  task automatic test_enable_drain();
    i_lines_per_frame = 16'd2; clear_log();
    load_frame(1, 2, 2, 32'h0200_0000); load_frame(3, 2, 2, 32'h0300_0000);
    exp_frame(1, 2, 2, 32'h0200_0000);
    refresh(); run(3);
    i_enable = 1'b0; refresh(); run(9);
    n_cmp++; if (rx_n !== exp_n) begin n_err++; $display("FAIL drain_rx_count got %0d required %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL drain_word%0d got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if ({o_frame_fifo_ready, o_busy} !== 2'b00) begin n_err++;
      $display("FAIL drain_idle got ready/busy %b required 00", {o_frame_fifo_ready, o_busy}); end
    n_cmp++; if (tail[3] - head[3] !== 4) begin n_err++; $display("FAIL drain_pending got %0d words required 4", tail[3] - head[3]); end
  endtask

  task automatic test_reset_mid_stream();
    i_enable = 1'b1; clear_log(); refresh();
    run(3);
    rst = 1'b1; run(1);
    n_cmp++; if ({o_frame_fifo_ready, o_busy, o_short_frame_stb} !== 3'b000) begin n_err++;
      $display("FAIL midrst_flags got %b required 000", {o_frame_fifo_ready, o_busy, o_short_frame_stb}); end
    n_cmp++; if (o_src_next_stb !== 4'b0000) begin n_err++; $display("FAIL midrst_pop got %b required 0000", o_src_next_stb); end
    n_cmp++; if (o_active_src !== 2'd0) begin n_err++; $display("FAIL midrst_active got %0d required 0", o_active_src); end
    n_cmp++; if (o_drop_count !== 16'd0) begin n_err++; $display("FAIL midrst_drop got %0d required 0", o_drop_count); end
    n_cmp++; if (o_frame_fifo_data !== 32'd0) begin n_err++; $display("FAIL midrst_data got %h required 0", o_frame_fifo_data); end
    rst = 1'b0; head[3] = tail[3]; clear_log();
    i_lines_per_frame = 16'd1;
    load_frame(2, 1, 1, 32'h0400_0000); load_frame(1, 1, 1, 32'h0500_0000);
    exp_frame(1, 1, 1, 32'h0500_0000); exp_frame(2, 1, 1, 32'h0400_0000);
    refresh(); run(12);
    n_cmp++; if (rx_n !== exp_n) begin n_err++; $display("FAIL midrst_rx_count got %0d required %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_rr_word%0d got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_two_frames();
    test_discard();
    test_abort();
    test_random_pop();
    test_enable_drain();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_fifo_frame_arbiter.md
# frame_fifo_frame_arbiter

Frame-granular round-robin scheduler that shares one frame FIFO read port (the port feeding the FIFO-to-AXI-stream converter) among NUM_SOURCES sensor-lane frame FIFOs. It grants one source at a time and passes that source through for exactly one frame, `i_lines_per_frame` lines. It resynchronises by discarding words that precede a start-of-frame, and rotates to the next ready source only at frame boundaries. Downstream therefore always sees whole, unmixed frames.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 32, data word width
- NUM_SOURCES, 4, number of upstream frame FIFOs (2..8)
- SRC_ID_WIDTH, 2, width of source index, equal to clog2(NUM_SOURCES)
- LINE_COUNT_WIDTH, 16, line counter and line config width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- i_enable  in  1  allow new grants; clearing it lets the current frame finish
- i_lines_per_frame  in  LINE_COUNT_WIDTH  lines per frame, sampled at grant; 0 is treated as 1
- i_src_ready  in  NUM_SOURCES  per-source head word valid
- o_src_next_stb  out  NUM_SOURCES  per-source pop strobe
- i_src_sof  in  NUM_SOURCES  per-source head word is start of frame
- i_src_last  in  NUM_SOURCES  per-source head word is end of line
- i_src_data  in  NUM_SOURCES*AXIS_DATA_WIDTH  source k occupies bits [k*W +: W]
- o_frame_fifo_ready  out  1  merged head word valid
- i_frame_fifo_next_stb  in  1  downstream pop
- o_frame_fifo_sof  out  1  merged sof
- o_frame_fifo_last  out  1  merged end of line
- o_frame_fifo_data  out  AXIS_DATA_WIDTH  merged data
- o_active_src  out  SRC_ID_WIDTH  granted source, registered
- o_busy  out  1  state is DISCARD or STREAM
- o_short_frame_stb  out  1  one-cycle pulse when a frame is aborted early
- o_drop_count  out  16  words discarded since reset; saturates at 0xFFFF

## Operation
- States: IDLE, GRANT, DISCARD, STREAM.
- IDLE:
  - Go to GRANT when i_enable=1 and any i_src_ready bit is set.
- GRANT (one cycle):
  - Select the first ready source in round-robin order, starting at rr_ptr.
  - Register it as o_active_src.
  - Latch max(i_lines_per_frame,1) into lines_cfg.
  - Clear line_cnt and beat_cnt.
  - If no source is ready, return to IDLE.
  - Next state is STREAM when the selected head has sof, otherwise DISCARD.
- DISCARD:
  - While the granted source is ready and its sof is low, assert o_src_next_stb[grant] and increment o_drop_count.
  - When the head has sof, go to STREAM.
  - When the source goes not-ready, stay in DISCARD.
  - Nothing is presented downstream in this state.
- STREAM, combinational pass-through:
  - o_frame_fifo_ready = i_src_ready[grant] & ~abort.
  - sof, last and data are muxed from the granted source.
  - o_src_next_stb[grant] = i_frame_fifo_next_stb & o_frame_fifo_ready.
  - A transfer is next_stb & ready; each transfer increments beat_cnt.
  - A transfer with last increments line_cnt and clears beat_cnt.
  - A last-transfer with line_cnt == lines_cfg-1 ends the frame: rr_ptr = grant+1 (mod NUM_SOURCES), then go to GRANT when i_enable=1, else IDLE.
  - Abort: head has sof while (line_cnt|beat_cnt) != 0.
    - Present ready=0 and do not pop.
    - Pulse o_short_frame_stb and set rr_ptr = grant+1.
    - Go to GRANT. The sof word stays in the source for its next grant.
- Non-granted sources always see o_src_next_stb = 0.
- Deasserting i_enable mid-frame has no effect until the frame ends.
- rst in any state returns the block to IDLE. Any partial frame is abandoned and its words are not popped further.

## Timing
- Reset values:
  - o_frame_fifo_ready, o_src_next_stb, o_busy and o_short_frame_stb are 0.
  - o_active_src, o_drop_count and rr_ptr are 0.
  - o_frame_fifo_sof, last and data read 0 whenever the state is not STREAM.
- Grant latency: from a source going ready in IDLE, GRANT follows on the next cycle and STREAM the cycle after. The first word is visible 2 cycles after ready.
- Frame-to-frame gap: exactly one GRANT cycle with ready=0.
- STREAM data path has zero latency: source-to-output and downstream-to-pop are combinational. Full throughput is one word per cycle.
- Discard rate: one word per cycle.
- Counter widths: line_cnt is LINE_COUNT_WIDTH bits and does not wrap, because the frame ends at lines_cfg. beat_cnt is 1 bit (non-zero flag).

## Structure
- Shared package frame_fifo_arb_pkg holds:
  - the state encoding localparams (IDLE=0, GRANT=1, DISCARD=2, STREAM=3);
  - the DROP_COUNT_WIDTH=16 constant.
- One sub-module, frame_fifo_rr_select:
  - combinational;
  - takes the request vector and rr_ptr;
  - returns the granted index and a valid flag.

## Test plan
- Sources 0 and 2 each hold one 2-line x 4-word frame, lines=2 -> downstream gets 8 words from src 0, then 8 from src 2, with one ready=0 gap; o_active_src goes 0 then 2.
- Src 1 head holds 3 non-sof words then a sof frame -> 3 discard pops, o_drop_count=3, then a clean frame starting with sof=1.
- Frame aborted after 1 line of 3 by a new sof -> o_short_frame_stb pulses once, sof word not popped; grant rotates, and src 1 is regranted later starting at that sof.
- Downstream next_stb toggled randomly during STREAM -> no pops without a transfer, and data order is preserved.
- i_enable cleared mid-frame -> current frame completes, then IDLE with ready=0 despite pending sources.
- rst asserted mid-STREAM -> next cycle all outputs at reset values, state IDLE, rr_ptr=0.
